// File: rtl/ppu_pkg.sv
// ppu_pkg: shared sprite-fetch state type, timing constants and helpers
package ppu_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} spr_state_t;

    localparam logic [8:0] SPR_FETCH_START   = 9'd256;
    localparam int         SPR_SLOTS         = 8;
    localparam logic [8:0] PRE_RENDER_LINE   = 9'd261;
    localparam logic [8:0] LAST_VISIBLE_LINE = 9'd239;
    localparam logic [3:0] LOAD_ALL          = 4'hF;
    localparam int         FETCH_DOTS        = SPR_SLOTS * 8;

    typedef struct packed {
        logic [7:0] pix1;
        logic [7:0] pix2;
        logic [7:0] x;
        logic [1:0] pal;
        logic       prio;
    } spr_load_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/spr_pattern_addr.sv
// spr_pattern_addr: sprite pattern table address from row offset, tile and plane
module spr_pattern_addr (
    input  logic        obj_size,
    input  logic        obj_patt,
    input  logic [3:0]  y,
    input  logic [7:0]  tile,
    input  logic        vflip,
    input  logic        plane,
    output logic [13:0] addr
);
    logic [3:0] row;
    always_comb begin
        row  = !vflip ? y : obj_size ? y ^ 4'hF : {y[3], y[2:0] ^ 3'h7};
        addr = obj_size ? {1'b0, tile[0], tile[7:1], row[3], plane, row[2:0]}
                        : {1'b0, obj_patt, tile, plane, row[2:0]};
    end
endmodule

// File: rtl/ppu_sprite_fetch.sv
// ppu_sprite_fetch: per-line sprite pattern fetch sequencer for dots 256..320
module ppu_sprite_fetch
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic [8:0]  i_cycle,
    input  logic [8:0]  i_scanline,
    input  logic        i_rendering,
    input  logic        i_obj_size,
    input  logic        i_obj_patt,
    input  logic [7:0]  i_oam_bus,
    output logic [13:0] o_vram_addr,
    output logic        o_vram_rd,
    input  logic [7:0]  i_vram_data,
    output logic [3:0]  o_load,
    output logic [26:0] o_load_data,
    output logic        o_busy
);
    spr_state_t state, nxt;
    logic [5:0] cnt;
    logic [2:0] phase;
    logic [7:0] y, tile, x, lo;
    logic       vflip, hflip, prio;
    logic [1:0] pal;
    logic [3:0] load;
    logic [13:0] paddr;
    logic       start, last, rd, empty, loading;
    spr_load_t  load_data, ld_next;

    assign phase = cnt[2:0];
    assign start = i_cycle == SPR_FETCH_START &&
                   (i_scanline <= LAST_VISIBLE_LINE || i_scanline == PRE_RENDER_LINE);

    always_comb begin
        last    = cnt == 6'(FETCH_DOTS - 1);
        nxt     = !i_rendering ? IDLE :
                  state == IDLE ? (start ? FETCH : IDLE) :
                  state == FETCH ? (last ? FLUSH : FETCH) : IDLE;
        rd      = state == FETCH && (phase == 3'd4 || phase == 3'd6);
        loading = state == FETCH && phase == 3'd7 && i_rendering;
        empty   = y[7:4] != 4'd0;
        // high byte goes straight from the bus into the load word at the end of phase7
        ld_next.pix1 = empty ? 8'h00 : hflip ? lo : rev8(lo);
        ld_next.pix2 = empty ? 8'h00 : hflip ? i_vram_data : rev8(i_vram_data);
        ld_next.x    = x;
        ld_next.pal  = pal;
        ld_next.prio = prio;
    end

    spr_pattern_addr u_addr (
        .obj_size (i_obj_size),
        .obj_patt (i_obj_patt),
        .y        (y[3:0]),
        .tile     (tile),
        .vflip    (vflip),
        .plane    (phase[1]),
        .addr     (paddr)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            y         <= '0;
            tile      <= '0;
            x         <= '0;
            lo        <= '0;
            vflip     <= 1'b0;
            hflip     <= 1'b0;
            prio      <= 1'b0;
            pal       <= '0;
            load      <= '0;
            load_data <= '0;
        end else if (i_ce) begin
            state <= nxt;
            cnt   <= state == FETCH && nxt == FETCH ? cnt + 6'd1 : '0;
            load  <= loading ? LOAD_ALL : 4'h0;
            if (loading) load_data <= ld_next;
            if (state == FETCH) begin
                if (phase == 3'd0) y <= i_oam_bus;
                if (phase == 3'd1) tile <= i_oam_bus;
                if (phase == 3'd2) {vflip, hflip, prio, pal} <= {i_oam_bus[7:5], i_oam_bus[1:0]};
                if (phase == 3'd3) x <= i_oam_bus;
                if (phase == 3'd5) lo <= i_vram_data;
            end
        end
    end

    assign o_vram_rd   = rd;
    assign o_vram_addr = rd ? paddr : 14'h0;
    assign o_load      = load;
    assign o_load_data = load_data;
    assign o_busy      = state != IDLE;
endmodule

// File: tb/tb_ppu_sprite_fetch.sv
// tb_ppu_sprite_fetch: directed line-by-line checks of the sprite fetch sequencer
module tb_ppu_sprite_fetch;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ce = 1'b0;
    logic [8:0]  i_cycle = '0;
    logic [8:0]  i_scanline = '0;
    logic        i_rendering = 1'b0;
    logic        i_obj_size = 1'b0;
    logic        i_obj_patt = 1'b0;
    logic [7:0]  i_oam_bus = '0;
    logic [7:0]  i_vram_data = '0;
    logic [13:0] o_vram_addr;
    logic        o_vram_rd;
    logic [3:0]  o_load;
    logic [26:0] o_load_data;
    logic        o_busy;

    int checks = 0;
    int failures = 0;
    logic [7:0]  sy[8], st[8], sa[8], sx[8];
    logic [13:0] elo[8], ehi[8];
    logic [26:0] eld[8];
    int   drop_dot, nrd, nld;
    logic line_ok, aborted, e_rd, e_ld;
    logic [13:0] e_addr;

    ppu_sprite_fetch dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_ce        (i_ce),
        .i_cycle     (i_cycle),
        .i_scanline  (i_scanline),
        .i_rendering (i_rendering),
        .i_obj_size  (i_obj_size),
        .i_obj_patt  (i_obj_patt),
        .i_oam_bus   (i_oam_bus),
        .o_vram_addr (o_vram_addr),
        .o_vram_rd   (o_vram_rd),
        .i_vram_data (i_vram_data),
        .o_load      (o_load),
        .o_load_data (o_load_data),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] vram(input logic [13:0] a);
        case (a)
            14'h1423: return 8'hF0;
            14'h142B: return 8'h0F;
            14'h1424: return 8'hF0;
            14'h142C: return 8'h3C;
            14'h1432: return 8'h01;
            14'h143A: return 8'h80;
            default:  return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    task automatic set_empty(input logic size);
        for (int k = 0; k < 8; k++) begin
            sy[k]  = 8'hFF;
            st[k]  = size ? 8'h00 : 8'(k);
            sa[k]  = 8'h23;
            sx[k]  = 8'(16 * k + 1);
            elo[k] = size ? 14'h0017 : (14'h1007 | 14'(k << 4));
            ehi[k] = elo[k] | 14'h0008;
            eld[k] = {16'h0, sx[k], 2'b11, 1'b1};
        end
    endtask

    task automatic check_dot(input int d, input string tag);
        int r, p, s;
        logic act;
        r   = d - 256;
        p   = r & 7;
        s   = (r >= 0) ? r / 8 : 0;
        act = line_ok && !aborted && r >= 0 && r <= 64 && d < drop_dot;
        e_rd   = act && r < 64 && (p == 4 || p == 6);
        e_addr = e_rd ? (p == 4 ? elo[s] : ehi[s]) : 14'h0;
        e_ld   = act && r >= 8 && p == 0;
        chk($sformatf("%s_busy@%0d", tag, d), 32'(o_busy), 32'(act));
        chk($sformatf("%s_rd@%0d", tag, d), 32'(o_vram_rd), 32'(e_rd));
        chk($sformatf("%s_addr@%0d", tag, d), 32'(o_vram_addr), 32'(e_addr));
        chk($sformatf("%s_load@%0d", tag, d), 32'(o_load), e_ld ? 32'hF : 32'h0);
        if (e_ld) chk($sformatf("%s_data@%0d", tag, d), 32'(o_load_data), 32'(eld[s-1]));
    endtask

    task automatic run_line(input logic [8:0] line, input logic size, input logic patt,
                            input int drop, input int rst_dot);
        int r, p, s;
        i_scanline  = line;
        i_obj_size  = size;
        i_obj_patt  = patt;
        i_rendering = 1'b1;
        drop_dot    = drop;
        line_ok     = line <= 9'd239 || line == 9'd261;
        aborted     = 1'b0;
        nrd = 0;
        nld = 0;
        for (int d = 250; d <= 330; d++) begin
            i_cycle = 9'(d);
            if (d >= drop) i_rendering = 1'b0;
            i_ce = 1'b1;
            @(posedge clk);
            #1;
            check_dot(d, "dot");
            if (o_vram_rd) nrd++;
            if (o_load != 4'h0) nld++;
            if (d == rst_dot) begin
                i_rst = 1'b1;
                #1;
                chk("rst_now_addr", 32'(o_vram_addr), 32'h0);
                chk("rst_now_rd", 32'(o_vram_rd), 32'h0);
                chk("rst_now_load", 32'(o_load), 32'h0);
                chk("rst_now_data", 32'(o_load_data), 32'h0);
                chk("rst_now_busy", 32'(o_busy), 32'h0);
                repeat (3) begin
                    i_ce = ~i_ce;
                    @(posedge clk);
                    #1;
                end
                chk("rst_held_busy", 32'(o_busy), 32'h0);
                chk("rst_held_load", 32'(o_load), 32'h0);
                @(negedge clk);
                i_rst   = 1'b0;
                aborted = 1'b1;
            end
            r = d - 256;
            if (r >= 0 && r < 64) begin
                p = r & 7;
                s = r / 8;
                i_oam_bus = p == 0 ? sy[s] : p == 1 ? st[s] : p == 2 ? sa[s] : p == 3 ? sx[s] : 8'hEE;
            end else begin
                i_oam_bus = 8'hEE;
            end
            if (e_rd) i_vram_data = vram(e_addr);
            // a ce-low clock with a tempting start dot must change nothing
            i_ce    = 1'b0;
            i_cycle = 9'd256;
            @(posedge clk);
            #1;
            check_dot(d, "hold");
        end
    endtask

    initial begin
        #3;
        chk("reset_async_busy", 32'(o_busy), 32'h0);
        chk("reset_async_load", 32'(o_load), 32'h0);
        chk("reset_async_data", 32'(o_load_data), 32'h0);
        chk("reset_async_rd", 32'(o_vram_rd), 32'h0);
        chk("reset_async_addr", 32'(o_vram_addr), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        chk("reset_release_busy", 32'(o_busy), 32'h0);

        set_empty(1'b0);
        sy[0] = 8'h03; st[0] = 8'h42; sa[0] = 8'h21; sx[0] = 8'h80;
        elo[0] = 14'h1423; ehi[0] = 14'h142B;
        eld[0] = {8'h0F, 8'hF0, 8'h80, 2'b01, 1'b1};
        run_line(9'd10, 1'b0, 1'b1, 1000, -1);
        chk("basic_reads", 32'(nrd), 32'd16);
        chk("basic_loads", 32'(nld), 32'd8);

        sa[0] = 8'hC0;
        elo[0] = 14'h1424; ehi[0] = 14'h142C;
        eld[0] = {8'hF0, 8'h3C, 8'h80, 2'b00, 1'b0};
        run_line(9'd10, 1'b0, 1'b1, 1000, -1);

        set_empty(1'b1);
        sy[0] = 8'h0A; st[0] = 8'h43; sa[0] = 8'h00; sx[0] = 8'h55;
        elo[0] = 14'h1432; ehi[0] = 14'h143A;
        eld[0] = {8'h80, 8'h01, 8'h55, 2'b00, 1'b0};
        run_line(9'd100, 1'b1, 1'b1, 1000, -1);

        set_empty(1'b0);
        run_line(9'd261, 1'b0, 1'b1, 1000, -1);
        chk("empty_reads", 32'(nrd), 32'd16);
        chk("empty_loads", 32'(nld), 32'd8);

        sy[0] = 8'h03; st[0] = 8'h42; sa[0] = 8'h21; sx[0] = 8'h80;
        elo[0] = 14'h1423; ehi[0] = 14'h142B;
        eld[0] = {8'h0F, 8'hF0, 8'h80, 2'b01, 1'b1};
        run_line(9'd10, 1'b0, 1'b1, 280, -1);
        chk("drop_loads", 32'(nld), 32'd2);

        run_line(9'd10, 1'b0, 1'b1, 1000, 270);
        chk("rst_mid_loads", 32'(nld), 32'd1);

        run_line(9'd240, 1'b0, 1'b1, 1000, -1);
        chk("vblank_reads", 32'(nrd), 32'd0);

        run_line(9'd10, 1'b0, 1'b1, 256, -1);
        chk("norender_loads", 32'(nld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ppu_sprite_fetch.md
PPU_SPRITE_FETCH -- requirements
Module: ppu_sprite_fetch

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 i_rst  in  1  reset, asynchronous, active-high.
REQ-003 i_ce  in  1  pixel clock enable; state advances only when high.
REQ-004 i_cycle  in  9  current dot, 0..340.
REQ-005 i_scanline  in  9  current line, 0..261.
REQ-006 i_rendering  in  1  sprites or background enabled.
REQ-007 i_obj_size  in  1  1 = 8x16 sprites.
REQ-008 i_obj_patt  in  1  8x8 sprite pattern table select.
REQ-009 i_oam_bus  in  8  sprite temp RAM byte presented during dots 256..319.
REQ-010 o_vram_addr  out  14  pattern fetch address.
REQ-011 o_vram_rd  out  1  pattern read strobe.
REQ-012 i_vram_data  in  8  pattern byte; valid at the ce edge ending the dot after o_vram_rd.
REQ-013 o_load  out  4  sprite shift-chain load strobes (pix1, pix2, x, attr/prio).
REQ-014 o_load_data  out  27  {pix1[7:0], pix2[7:0], x[7:0], pal[1:0], prio}.
REQ-015 o_busy  out  1  high in FETCH or FLUSH.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH (64 dots), FLUSH (1 dot).
- IDLE->FETCH: ce edge with i_cycle==256, i_rendering==1, i_scanline<=239 or ==261.
- FETCH->FLUSH: after 64 dots. FLUSH->IDLE: next ce edge.
REQ-017 FETCH SHALL use an internal 6-bit counter {slot[2:0], phase[2:0]}, cleared on entry; it SHALL NOT be re-derived from i_cycle.
REQ-018 Capture i_oam_bus at the end of each phase: phase0 = Y offset, phase1 = tile, phase2 = attr, phase3 = X.
REQ-019 Row SHALL be Y[3:0]; if attr[7] (vflip), row = Y[3:0] ^ 4'hF for 8x16, else Y[2:0] ^ 3'h7.
REQ-020 Address rules:
- 8x8: {0, i_obj_patt, tile, plane, row[2:0]}.
- 8x16: {0, tile[0], tile[7:1], row[3], plane, row[2:0]}.
- plane = 0 in phase4, 1 in phase6.
REQ-021 o_vram_rd SHALL be 1 exactly during phases 4 and 6 of FETCH.
- Low byte captured at end of phase5; high byte captured at end of phase7.
REQ-022 Pixel order: pix bit0 = leftmost pixel.
- attr[6]==0: captured bytes bit-reversed.
- attr[6]==1: stored as-is.
REQ-023 Empty slot (Y[7:4] != 0): pix1 = pix2 = 0; x, pal, prio loaded as captured. Fetch strobes still issued.
REQ-024 o_load = 4'hF for exactly one dot per slot k, during dot 264+8k (k = 0..7).
- Slots 0..6: during phase0 of the next slot.
- Slot 7: during FLUSH (dot 320).
- o_load = 0 at all other times.
REQ-025 o_load_data SHALL be held stable for the whole dot in which o_load is nonzero.
- Field mapping: pal = attr[1:0]; prio = attr[5].
REQ-026 i_rendering falling in FETCH/FLUSH: return to IDLE at the next ce edge; no further o_vram_rd or o_load; partial slot discarded.
REQ-027 i_ce low: all registers and outputs hold, including strobes.
REQ-028 Simultaneous start condition and i_rendering low: remain IDLE.

Reset
REQ-029 While i_rst is high, regardless of clk:
- State = IDLE; counter = 0; all capture registers = 0.
- o_vram_addr = 0, o_vram_rd = 0, o_load = 0, o_load_data = 0, o_busy = 0.
REQ-030 Reset asserted mid-FETCH: no load strobe after deassertion until the next valid start at dot 256.

Structure
REQ-031 Shared package ppu_pkg SHALL hold:
- FSM state typedef.
- Constants SPR_FETCH_START=256, SPR_SLOTS=8, PRE_RENDER_LINE=261, LOAD_ALL=4'hF.
REQ-032 Address generation (REQ-019/020) SHALL be a combinational sub-module spr_pattern_addr.

Verification
REQ-033 Line 10, 8x8, obj_patt=1, slot0 bytes Y=03 tile=0x42 attr=0x21 X=0x80, VRAM 0x1423=0xF0, 0x142B=0x0F.
- Expect reads at dots 260/262 to 0x1423/0x142B.
- Expect o_load=F at dot 264, data {0x0F, 0xF0, 0x80, 2'b01, 1}.
REQ-034 Same sprite with attr=0xC0 (hflip+vflip):
- Expect address 0x1424.
- Expect pix1=0xF0 unreversed.
REQ-035 8x16, tile=0x43, Y=0x0A: expect addresses 0x1432 and 0x143A.
REQ-036 All slots empty (Y=0xFF): expect 16 reads, 8 loads at dots 264..320, all pix=0.
REQ-037 i_rendering dropped at dot 280: expect loads at 264 and 272 only, IDLE by 281, o_busy=0.
REQ-038 i_rst pulsed at dot 270 with i_ce toggling: expect all outputs 0 immediately, no load at 272.
